weight_bank_ctrl: RTL and testbench
===================================

Name: weight_bank_ctrl

Overview:
- Sequencer for the 8-bank URAM weight store (8 banks x 72 bits, 576-bit entries).
- Load path: accepts a 72-bit weight stream, distributes consecutive words round-robin across banks 0..7, and advances the entry address after every bank-7 word.
- Read path: issues a burst of entry reads for the conv engine and produces an rdata_valid strobe aligned to the bank's fixed read latency.
- Load and read are mutually exclusive, so no read-after-write hazard can occur.

Parameters:
- DEPTH, 4096, entries per bank.
- ADDR_WIDTH, $clog2(DEPTH), entry address width.
- NUM_BANKS, 8, banks per entry. Fixed; other values unsupported.
- RD_LATENCY, 3, cycles from ren sampled to rdata valid at the bank output.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  pulse; begins a load of load_words entries at load_base.
- load_base  in  ADDR_WIDTH  first entry address, sampled on accepted load_start.
- load_words  in  ADDR_WIDTH+1  number of 576-bit entries to load (0..DEPTH).
- s_valid  in  1  weight stream valid.
- s_data  in  72  weight word.
- s_ready  out  1  weight stream ready.
- load_busy  out  1  load in progress.
- load_done  out  1  one-cycle pulse, load complete.
- rd_start  in  1  pulse; begins a read burst.
- rd_base  in  ADDR_WIDTH  first entry address, sampled on accepted rd_start.
- rd_count  in  ADDR_WIDTH+1  entries to read (0..DEPTH).
- rd_hold  in  1  consumer pause; suppresses issue in the current cycle.
- rd_busy  out  1  burst in progress, including in-flight data.
- rd_done  out  1  one-cycle pulse coincident with the last rdata_valid.
- rdata_valid  out  1  bank rdata holds a requested entry this cycle.
- wen  out  1 x [0:7]  per-bank write enable to the bank.
- wdata  out  72  bank write data.
- waddr  out  ADDR_WIDTH  bank write address.
- ren  out  1 x [0:7]  per-bank read enable to the bank.
- raddr  out  ADDR_WIDTH  bank read address.

Behaviour:
- Reset: all outputs are 0. Both FSMs go to IDLE. The valid shift register is cleared. Reset mid-operation aborts with no done pulse. Bank contents are undefined and are not cleared.
- Load FSM states: IDLE, LOAD, DONE.
  - load_start is accepted only when both FSMs are IDLE; otherwise it is ignored.
  - Accepted with load_words=0: go to DONE, pulse load_done the next cycle, perform no writes.
  - LOAD: s_ready=1 and load_busy=1.
  - On each handshake (s_valid and s_ready), in the next cycle: wen[bank_idx]=1 (only that bit), wdata=s_data, waddr=(load_base+entry_idx) mod DEPTH. All write outputs are registered.
  - bank_idx increments 0..7. At 7 it wraps to 0 and entry_idx increments.
  - When the handshake is for bank 7 of the last entry, s_ready drops the next cycle and the FSM enters DONE.
  - DONE: load_done=1 for one cycle, coincident with the final wen. Then return to IDLE.
  - Gaps in s_valid stall the counters, with no wen in those cycles.
- Read FSM states: IDLE, ISSUE, DRAIN.
  - rd_start is accepted only when both FSMs are IDLE; otherwise it is ignored.
  - Simultaneous load_start and rd_start in IDLE: load wins and rd_start is dropped.
  - rd_count=0: rd_busy and rd_done pulse together for one cycle, then return to IDLE, with no ren.
  - ISSUE, each cycle with rd_hold=0: the next registered cycle drives ren[0:7] all 1 and raddr=(rd_base+issued) mod DEPTH, then issued increments.
  - ISSUE, rd_hold=1: ren=0 and the counter holds.
  - After the last issue, go to DRAIN.
  - rdata_valid is the ren-issue bit delayed RD_LATENCY cycles. ren high in cycle t gives rdata_valid in cycle t+RD_LATENCY. Holes created by rd_hold propagate as holes in rdata_valid.
  - rd_done pulses with the final rdata_valid. rd_busy falls the cycle after.
  - Back-to-back bursts are allowed: a new rd_start is accepted in the first IDLE cycle.
- Address arithmetic is modulo DEPTH: base DEPTH-1 wraps to 0.
- rd_hold is ignored outside ISSUE.

Test Plan:
- Load of 1 entry: load_base=5, load_words=1, 8 back-to-back words 0x01..0x08. Required: wen[i] one-hot in cycles 1..8, waddr=5, wdata=i+1, load_done with the 8th wen, 8 handshakes total.
- Stalled stream: load_words=2 with s_valid toggling every other cycle. Required: 16 writes, waddr 5 for banks 0..7 then 6, no wen during gaps, load_done once.
- Read burst: rd_base=10, rd_count=4, rd_hold high on the 2nd issue cycle. Required: raddr sequence 10,11,12,13 with a one-cycle ren gap; rdata_valid pattern 1,0,1,1,1 starting 3 cycles after the first ren; rd_done on the last valid.
- Wrap and zero count: rd_base=4095, rd_count=2 gives raddr 4095 then 0. rd_count=0 gives rd_done the next cycle with no ren. load_words=0 gives load_done with no wen.
- Collisions: rd_start during LOAD is ignored (no ren). Simultaneous load_start and rd_start in IDLE runs only the load.
- Reset mid-read after 2 of 6 issues: all outputs 0 the next cycle, rdata_valid stays 0, no rd_done. A fresh rd_start is accepted afterwards.

Source files
------------

// File: rtl/weight_bank_ctrl.sv
// Load/read sequencer for the 8-bank x 72-bit URAM weight store.
// Load stripes a 72-bit stream across banks; read issues bursts with a fixed-latency valid.

module wbc_bank_lane (
  input  logic clk,
  input  logic rst,
  input  logic wr_hit,
  input  logic rd_hit,
  output logic wen,
  output logic ren
);
  always_ff @(posedge clk) begin
    if (rst) begin
      wen <= 1'b0;
      ren <= 1'b0;
    end else begin
      wen <= wr_hit;
      ren <= rd_hit;
    end
  end
endmodule

module weight_bank_ctrl #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_BANKS  = 8,
  parameter int RD_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic [ADDR_WIDTH-1:0]  load_base,
  input  logic [ADDR_WIDTH:0]    load_words,
  input  logic                   s_valid,
  input  logic [71:0]            s_data,
  output logic                   s_ready,
  output logic                   load_busy,
  output logic                   load_done,
  input  logic                   rd_start,
  input  logic [ADDR_WIDTH-1:0]  rd_base,
  input  logic [ADDR_WIDTH:0]    rd_count,
  input  logic                   rd_hold,
  output logic                   rd_busy,
  output logic                   rd_done,
  output logic                   rdata_valid,
  output logic [0:NUM_BANKS-1]   wen,
  output logic [71:0]            wdata,
  output logic [ADDR_WIDTH-1:0]  waddr,
  output logic [0:NUM_BANKS-1]   ren,
  output logic [ADDR_WIDTH-1:0]  raddr
);
  localparam int BW = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} lstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rstate_t;

  lstate_t ls, ls_nxt;
  rstate_t rs, rs_nxt;

  logic [ADDR_WIDTH-1:0] l_base, r_base;
  logic [ADDR_WIDTH:0]   l_words, entry_idx, r_count, issued;
  logic [BW-1:0]         bank_idx;
  logic                  r_zero;
  logic [RD_LATENCY:0]   vld_pipe, last_pipe;

  logic both_idle, load_acc, rd_acc, hs, l_last, issue, r_last;

  always_comb begin
    both_idle = (ls == L_IDLE) && (rs == R_IDLE);
    load_acc  = both_idle && load_start;
    // load has priority over a same-cycle read request
    rd_acc    = both_idle && rd_start && !load_start;
    s_ready   = (ls == L_LOAD);
    load_busy = (ls != L_IDLE);
    load_done = (ls == L_DONE);
    hs        = s_valid && s_ready;
    l_last    = hs && (bank_idx == BW'(NUM_BANKS - 1)) && (entry_idx == l_words - 1'b1);
    issue     = (rs == R_ISSUE) && !rd_hold;
    r_last    = issue && (issued == r_count - 1'b1);
    rd_busy   = (rs != R_IDLE);
    rd_done   = (rs == R_DRAIN) && (r_zero || last_pipe[RD_LATENCY]);
    rdata_valid = vld_pipe[RD_LATENCY];

    ls_nxt = ls;
    case (ls)
      L_IDLE: if (load_acc) ls_nxt = (load_words == '0) ? L_DONE : L_LOAD;
      L_LOAD: if (l_last)   ls_nxt = L_DONE;
      default:              ls_nxt = L_IDLE;
    endcase

    rs_nxt = rs;
    case (rs)
      R_IDLE:  if (rd_acc)  rs_nxt = (rd_count == '0) ? R_DRAIN : R_ISSUE;
      R_ISSUE: if (r_last)  rs_nxt = R_DRAIN;
      R_DRAIN: if (rd_done) rs_nxt = R_IDLE;
      default:              rs_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ls        <= L_IDLE;
      rs        <= R_IDLE;
      l_base    <= '0;
      l_words   <= '0;
      bank_idx  <= '0;
      entry_idx <= '0;
      r_base    <= '0;
      r_count   <= '0;
      issued    <= '0;
      r_zero    <= 1'b0;
      wdata     <= '0;
      waddr     <= '0;
      raddr     <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      ls <= ls_nxt;
      rs <= rs_nxt;
      if (load_acc) begin
        l_base    <= load_base;
        l_words   <= load_words;
        bank_idx  <= '0;
        entry_idx <= '0;
      end
      if (hs) begin
        wdata    <= s_data;
        waddr    <= l_base + entry_idx[ADDR_WIDTH-1:0];
        bank_idx <= bank_idx + 1'b1;
        if (bank_idx == BW'(NUM_BANKS - 1)) entry_idx <= entry_idx + 1'b1;
      end
      if (rd_acc) begin
        r_base  <= rd_base;
        r_count <= rd_count;
        issued  <= '0;
        r_zero  <= (rd_count == '0);
      end
      if (issue) begin
        raddr  <= r_base + issued[ADDR_WIDTH-1:0];
        issued <= issued + 1'b1;
      end
      // stage 0 mirrors ren; the top stage lines up with bank read data
      vld_pipe  <= {vld_pipe[RD_LATENCY-1:0], issue};
      last_pipe <= {last_pipe[RD_LATENCY-1:0], r_last};
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    wbc_bank_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .wr_hit (hs && (bank_idx == BW'(b))),
      .rd_hit (issue),
      .wen    (wen[b]),
      .ren    (ren[b])
    );
  end
endmodule

// File: tb/tb_weight_bank_ctrl.sv
// Scoreboard bench for weight_bank_ctrl: expected writes/reads queued at drive time,
// popped and compared by a negedge monitor.

module tb_weight_bank_ctrl;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int RL    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_words;
  logic          s_valid;
  logic [71:0]   s_data;
  logic          s_ready, load_busy, load_done;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_count;
  logic          rd_hold;
  logic          rd_busy, rd_done, rdata_valid;
  logic [0:7]    wen, ren;
  logic [71:0]   wdata;
  logic [AW-1:0] waddr, raddr;

  weight_bank_ctrl dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_base(load_base), .load_words(load_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_busy(load_busy), .load_done(load_done),
    .rd_start(rd_start), .rd_base(rd_base), .rd_count(rd_count), .rd_hold(rd_hold),
    .rd_busy(rd_busy), .rd_done(rd_done), .rdata_valid(rdata_valid),
    .wen(wen), .wdata(wdata), .waddr(waddr), .ren(ren), .raddr(raddr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int n_wen = 0, n_ren = 0, n_val = 0, n_rdd = 0, n_ldd = 0;

  typedef struct { int bank; int addr; logic [71:0] data; bit last; } wexp_t;
  typedef struct { int addr; int cyc; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];
  int    vq[$];
  int    dq[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    wexp_t we;
    rexp_t re;
    logic [0:7] ev;
    int c;
    if (wen != '0) begin
      n_wen++;
      if (wq.size() == 0) chk("wen_unexp", 1, 0);
      else begin
        we = wq.pop_front();
        ev = '0;
        ev[we.bank] = 1'b1;
        chk("wen", wen, ev);
        chk("waddr", waddr, we.addr);
        chk("wdata", wdata, we.data);
        chk("ld_done_align", load_done, we.last);
      end
    end
    if (load_done) n_ldd++;
    if (ren != '0) begin
      n_ren++;
      if (rq.size() == 0) chk("ren_unexp", 1, 0);
      else begin
        re = rq.pop_front();
        chk("ren_all", ren, 8'hFF);
        chk("raddr", raddr, re.addr);
        chk("ren_cyc", cyc, re.cyc);
      end
    end
    if (rdata_valid) begin
      n_val++;
      if (vq.size() == 0) chk("valid_unexp", 1, 0);
      else begin c = vq.pop_front(); chk("valid_cyc", cyc, c); end
    end
    if (rd_done) begin
      n_rdd++;
      if (dq.size() == 0) chk("rd_done_unexp", 1, 0);
      else begin c = dq.pop_front(); chk("rd_done_cyc", cyc, c); end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return {10'd0, wen, ren, raddr, waddr, wdata, s_ready, load_busy, load_done,
            rd_busy, rd_done, rdata_valid};
  endfunction

  task automatic do_load(input int base, input int words, input bit seq, input bit gap,
                         input bit also_rd, input bit poke_rd);
    int ld0, w0, r0, tmo;
    logic [71:0] d;
    ld0 = n_ldd; w0 = n_wen; r0 = n_ren;
    load_base = AW'(base); load_words = (AW+1)'(words); load_start = 1'b1;
    rd_start = also_rd; rd_base = 12'd7; rd_count = 13'd3;
    step;
    load_start = 1'b0; rd_start = 1'b0;
    for (int i = 0; i < words * 8; i++) begin
      d = seq ? 72'(i + 1) : {8'(i), 32'($urandom), 32'($urandom)};
      s_valid = 1'b1; s_data = d;
      rd_start = poke_rd && (i == 3);
      tmo = 0;
      while (!s_ready && tmo < 20) begin step; tmo++; end
      if (tmo == 20) begin chk("hs_timeout", 0, 1); break; end
      wq.push_back('{i % 8, (base + i / 8) % DEPTH, d, (i == words * 8 - 1)});
      step;
      rd_start = 1'b0;
      if (gap) begin s_valid = 1'b0; step; end
    end
    s_valid = 1'b0;
    chk("s_ready_drop", s_ready, 0);
    step; step;
    chk("ld_done_cnt", n_ldd - ld0, 1);
    chk("wen_cnt", n_wen - w0, words * 8);
    chk("wq_empty", wq.size(), 0);
    chk("no_ren_in_load", n_ren - r0, 0);
    chk("load_busy_end", load_busy, 0);
  endtask

  task automatic do_read(input int base, input int count, input logic [31:0] hold_mask);
    int r0, v0, d0, issued, c;
    r0 = n_ren; v0 = n_val; d0 = n_rdd;
    rd_base = AW'(base); rd_count = (AW+1)'(count); rd_start = 1'b1;
    if (count == 0) dq.push_back(cyc + 1);
    step;
    rd_start = 1'b0;
    if (count == 0) begin
      chk("zero_busy", rd_busy, 1);
      chk("zero_done", rd_done, 1);
    end
    issued = 0; c = 0;
    while (issued < count && c < 64) begin
      rd_hold = (c < 32) ? hold_mask[c] : 1'b0;
      if (!rd_hold) begin
        rq.push_back('{(base + issued) % DEPTH, cyc + 1});
        vq.push_back(cyc + 1 + RL);
        if (issued == count - 1) dq.push_back(cyc + 1 + RL);
        issued++;
      end
      step;
      c++;
    end
    rd_hold = 1'b0;
    repeat (RL + 2) step;
    chk("rd_busy_end", rd_busy, 0);
    chk("ren_cnt", n_ren - r0, count);
    chk("valid_cnt", n_val - v0, count);
    chk("rd_done_cnt", n_rdd - d0, 1);
    chk("rq_empty", rq.size() + vq.size() + dq.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int v0, d0;
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_words = '0;
    s_valid = 1'b0; s_data = '0; rd_start = 1'b0; rd_base = '0; rd_count = '0; rd_hold = 1'b0;
    repeat (3) step;
    chk("reset_outs", all_outs(), 0);
    rst = 1'b0;
    step;

    do_load(5, 1, 1'b1, 1'b0, 1'b0, 1'b0);   // single entry, sequential data
    do_load(5, 2, 1'b0, 1'b1, 1'b0, 1'b0);   // stalled stream
    do_read(10, 4, 32'b10);                  // hold on 2nd issue cycle
    do_read(4095, 2, 32'b0);                 // address wrap
    do_read(0, 0, 32'b0);                    // zero count
    do_load(77, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // zero-word load
    do_load(20, 1, 1'b0, 1'b0, 1'b1, 1'b1);  // simultaneous start + rd_start during LOAD
    do_read(DEPTH - 2, 5, 32'b0101);         // back-to-back, wrap with holes
    do_read(300, 3, 32'b0);

    // reset in the middle of a burst after two issues
    v0 = n_val; d0 = n_rdd;
    rd_base = 12'd100; rd_count = 13'd6; rd_start = 1'b1;
    step;
    rd_start = 1'b0;
    rq.push_back('{100, cyc + 1});
    step;
    rq.push_back('{101, cyc + 1});
    step;
    rst = 1'b1;
    step;
    chk("rst_mid_outs", all_outs(), 0);
    rst = 1'b0;
    repeat (6) step;
    chk("rst_no_valid", n_val - v0, 0);
    chk("rst_no_done", n_rdd - d0, 0);
    chk("rst_rq_empty", rq.size(), 0);
    do_read(200, 3, 32'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
